nbj_correct_arb: RTL and testbench

//  Arbitrates PC-correction requests from NUM_REQ non-branch-jump detectors into the single

---
 rtl/nbj_correct_arb.sv | 108 ++++++++++
 tb/tb_nbj_correct_arb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nbj_correct_arb.sv
// Arbiter funnelling PC-correction requests from several non-branch-jump detectors
// into one correction path, with per-requester holding slots and a post-grant hold-off.
module nbj_correct_arb #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int IDW         = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    i_reqValid,
  input  logic [NUM_REQ*36-1:0] i_reqData,
  output logic [NUM_REQ-1:0]    o_reqReady,
  input  logic                  i_flush,
  output logic                  o_fire,
  output logic [35:0]           o_data_36,
  output logic [IDW-1:0]        o_grantId,
  output logic                  o_busy
);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDW-1:0]     rr_ptr;
  logic [NUM_REQ-1:0] slot_vld_p0;
  logic [35:0]        slot_data_p0 [NUM_REQ];

  logic [NUM_REQ-1:0] err_mask;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] capture;
  logic [NUM_REQ-1:0] win_onehot;
  logic [IDW-1:0]     win_idx;
  logic [IDW-1:0]     scan_idx;
  logic               win_found;
  logic               grant;
  logic [IDW-1:0]     rr_next;

  // Stage p0 -> selection: errType=1 slots take priority, then round-robin from rr_ptr
  always_comb begin
    err_mask = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      err_mask[r] = slot_vld_p0[r] & slot_data_p0[r][35];
    end
  end

  assign cand = (|err_mask) ? err_mask : slot_vld_p0;

  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!win_found && cand[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign grant      = (state == IDLE) && (|slot_vld_p0) && !i_flush;
  assign capture    = i_reqValid & ~slot_vld_p0 & {NUM_REQ{~i_flush}};
  assign win_onehot = grant ? (NUM_REQ'(1) << win_idx) : '0;
  assign rr_next    = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + IDW'(1);

  assign o_reqReady = ~slot_vld_p0;
  assign o_busy     = (state == HOLD) || (|slot_vld_p0);

  // Stage p1: grant registers, slot occupancy and hold-off FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rr_ptr      <= '0;
      slot_vld_p0 <= '0;
      o_fire      <= 1'b0;
      o_data_36   <= '0;
      o_grantId   <= '0;
    end else begin
      o_fire <= grant;
      if (i_flush) begin
        slot_vld_p0 <= '0;
        state       <= IDLE;
        cnt         <= '0;
      end else begin
        slot_vld_p0 <= (slot_vld_p0 | capture) & ~win_onehot;
        if (grant) begin
          state     <= HOLD;
          cnt       <= CNT_W'(HOLD_CYCLES);
          rr_ptr    <= rr_next;
          o_data_36 <= slot_data_p0[win_idx];
          o_grantId <= win_idx;
        end else if (state == HOLD) begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REQ; r++) begin
      if (capture[r]) slot_data_p0[r] <= i_reqData[r*36 +: 36];
    end
  end

endmodule

// File: tb/tb_nbj_correct_arb.sv
// Randomised and directed bench for nbj_correct_arb: a request-level model predicts each
// grant, and a monitor matches every o_fire pulse against the expected-grant queue.
module tb_nbj_correct_arb;
  localparam int N  = 4;
  localparam int HC = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*36-1:0] req_data;
  logic           flush;
  logic [N-1:0]   req_ready;
  logic           fire;
  logic [35:0]    data;
  logic [1:0]     grant_id;
  logic           busy;

  logic [N-1:0]   v1;
  logic [N*36-1:0] d1;
  logic [N-1:0]   ready1;
  logic           fire1;
  logic [35:0]    data1;
  logic [1:0]     gid1;
  logic           busy1;

  nbj_correct_arb #(.NUM_REQ(N), .HOLD_CYCLES(HC), .IDW(2)) dut (
    .clk(clk), .rst(rst), .i_reqValid(req_valid), .i_reqData(req_data),
    .o_reqReady(req_ready), .i_flush(flush), .o_fire(fire), .o_data_36(data),
    .o_grantId(grant_id), .o_busy(busy));

  nbj_correct_arb #(.NUM_REQ(N), .HOLD_CYCLES(1), .IDW(2)) dut1 (
    .clk(clk), .rst(rst), .i_reqValid(v1), .i_reqData(d1),
    .o_reqReady(ready1), .i_flush(1'b0), .o_fire(fire1), .o_data_36(data1),
    .o_grantId(gid1), .o_busy(busy1));

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic nc();
    @(negedge clk);
  endtask

  // Request-level model: occupancy per requester, round-robin start, cycles left before a grant
  typedef struct {
    int          edge_idx;
    logic [35:0] data;
    int          id;
  } exp_t;

  exp_t        sbq[$];
  bit          occ [N];
  logic [35:0] sdata [N];
  int          rr = 0;
  int          hold_left = 0;
  int          last_id = 0;
  logic [35:0] last_data = '0;
  int          edge_n = 0;

  function automatic int pick();
    bit any_err = 1'b0;
    for (int r = 0; r < N; r++) if (occ[r] && sdata[r][35]) any_err = 1'b1;
    for (int k = 0; k < N; k++) begin
      int r = (rr + k) % N;
      if (occ[r] && (!any_err || sdata[r][35])) return r;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < N; r++) occ[r] = 1'b0;
      rr = 0; hold_left = 0; last_id = 0; last_data = '0;
      sbq.delete();
    end else begin
      bit pre [N];
      int w;
      w = -1;
      for (int r = 0; r < N; r++) pre[r] = occ[r];
      if (flush) begin
        for (int r = 0; r < N; r++) occ[r] = 1'b0;
        hold_left = 0;
      end else begin
        if (hold_left > 0) hold_left--;
        else w = pick();
        for (int r = 0; r < N; r++) begin
          if (req_valid[r] && !pre[r]) begin
            occ[r]   = 1'b1;
            sdata[r] = req_data[r*36 +: 36];
          end
        end
        if (w >= 0) begin
          occ[w] = 1'b0;
          sbq.push_back('{edge_n, sdata[w], w});
          rr        = (w + 1) % N;
          hold_left = HC;
          last_data = sdata[w];
          last_id   = w;
        end
      end
      edge_n++;
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      logic [N-1:0] mready;
      bit           mbusy;
      exp_t         e;
      mbusy = (hold_left > 0);
      for (int r = 0; r < N; r++) begin
        mready[r] = !occ[r];
        if (occ[r]) mbusy = 1'b1;
      end
      if (fire) begin
        if (sbq.size() == 0) check("unexpected_fire", 64'(1), 64'(0));
        else begin
          e = sbq.pop_front();
          check("fire_cycle", 64'(edge_n - 1), 64'(e.edge_idx));
          check("fire_data", 64'(data), 64'(e.data));
          check("fire_id", 64'(grant_id), 64'(e.id));
        end
      end else if (sbq.size() > 0 && sbq[0].edge_idx == edge_n - 1) begin
        check("missing_fire", 64'(0), 64'(1));
        void'(sbq.pop_front());
      end
      check("data_held", 64'(data), 64'(last_data));
      check("grant_id_held", 64'(grant_id), 64'(last_id));
      check("ready", 64'(req_ready), 64'(mready));
      check("busy", 64'(busy), 64'(mbusy));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ids[$];
    rst = 1'b1; req_valid = '0; req_data = '0; flush = 1'b0; v1 = '0; d1 = '0;
    #2 rst = 1'b0;
    #1;
    check("rst_fire", 64'(fire), 64'(0));
    check("rst_data", 64'(data), 64'(0));
    check("rst_gid", 64'(grant_id), 64'(0));
    check("rst_ready", 64'(req_ready), 64'hF);
    check("rst_busy", 64'(busy), 64'(0));
    nc(); #3 rst = 1'b1;

    // HOLD_CYCLES=1 instance: two pending slots fire two cycles apart
    nc();
    v1 = 4'b0011;
    d1[0 +: 36]  = {1'b0, 3'd1, 32'h0000_1110};
    d1[36 +: 36] = {1'b0, 3'd2, 32'h0000_2220};
    nc(); v1 = '0;
    check("h1_c1_fire", 64'(fire1), 64'(0));
    nc();
    check("h1_c2_fire", 64'(fire1), 64'(1));
    check("h1_c2_id", 64'(gid1), 64'(0));
    check("h1_c2_data", 64'(data1), 64'h1_0000_1110);
    nc();
    check("h1_c3_fire", 64'(fire1), 64'(0));
    nc();
    check("h1_c4_fire", 64'(fire1), 64'(1));
    check("h1_c4_id", 64'(gid1), 64'(1));
    check("h1_c4_busy", 64'(busy1), 64'(1));
    nc();
    check("h1_c5_busy", 64'(busy1), 64'(0));

    // All requesters hold errType-0 requests; round robin from pointer 0
    for (int r = 0; r < N; r++) req_data[r*36 +: 36] = {1'b0, 3'(r), 32'h1000_0000 + 32'(r)};
    req_valid = 4'b1111;
    for (int c = 1; c <= 16; c++) begin
      nc();
      if (fire) ids.push_back(int'(grant_id));
    end
    req_valid = '0;
    check("rr_count", 64'(ids.size() >= 5), 64'(1));
    if (ids.size() >= 5) begin
      check("rr_0", 64'(ids[0]), 64'(0));
      check("rr_1", 64'(ids[1]), 64'(1));
      check("rr_2", 64'(ids[2]), 64'(2));
      check("rr_3", 64'(ids[3]), 64'(3));
      check("rr_4", 64'(ids[4]), 64'(0));
    end
    repeat (20) nc();

    // Single request latency
    req_valid = 4'b0100;
    req_data[72 +: 36] = {1'b0, 3'd3, 32'h8000_0040};
    nc(); req_valid = '0;
    check("t1_slot_full", 64'(req_ready[2]), 64'(0));
    nc();
    check("t1_fire", 64'(fire), 64'(1));
    check("t1_data", 64'(data), 64'h3_8000_0040);
    check("t1_gid", 64'(grant_id), 64'(2));
    check("t1_ready", 64'(req_ready[2]), 64'(1));
    repeat (4) nc();

    // errType=1 request wins over an earlier round-robin candidate
    req_valid = 4'b1001;
    req_data[0 +: 36]   = {1'b0, 3'd0, 32'h0000_0100};
    req_data[108 +: 36] = {1'b1, 3'd5, 32'h0000_0300};
    nc(); req_valid = '0;
    nc();
    check("t2_first_fire", 64'(fire), 64'(1));
    check("t2_first_id", 64'(grant_id), 64'(3));
    nc(); nc(); nc();
    check("t2_second_fire", 64'(fire), 64'(1));
    check("t2_second_id", 64'(grant_id), 64'(0));
    repeat (4) nc();

    // Flush in the would-grant cycle
    req_valid = 4'b0110;
    req_data[36 +: 36] = {1'b0, 3'd1, 32'h0000_0A00};
    req_data[72 +: 36] = {1'b0, 3'd2, 32'h0000_0B00};
    nc(); req_valid = '0; flush = 1'b1;
    nc(); flush = 1'b0;
    check("t4_no_fire", 64'(fire), 64'(0));
    check("t4_ready", 64'(req_ready), 64'hF);
    check("t4_busy", 64'(busy), 64'(0));
    req_valid = 4'b0110;
    nc(); req_valid = '0;
    nc();
    check("t4_regrant_fire", 64'(fire), 64'(1));
    check("t4_regrant_id", 64'(grant_id), 64'(1));
    repeat (8) nc();

    // Asynchronous reset while the fire pulse is high
    req_valid = 4'b0001;
    req_data[0 +: 36] = {1'b0, 3'd4, 32'h0000_0C00};
    nc(); req_valid = '0;
    nc();
    #2 rst = 1'b0;
    #1;
    check("t5_fire", 64'(fire), 64'(0));
    check("t5_data", 64'(data), 64'(0));
    check("t5_gid", 64'(grant_id), 64'(0));
    check("t5_ready", 64'(req_ready), 64'hF);
    check("t5_busy", 64'(busy), 64'(0));
    nc(); #3 rst = 1'b1;
    nc();
    req_valid = 4'b0100;
    req_data[72 +: 36] = {1'b0, 3'd6, 32'h0000_0D00};
    nc(); req_valid = '0;
    nc();
    check("t5_after_fire", 64'(fire), 64'(1));
    check("t5_after_id", 64'(grant_id), 64'(2));
    repeat (4) nc();

    // Random traffic with occasional flushes
    repeat (600) begin
      nc();
      req_valid = 4'($urandom & $urandom);
      for (int r = 0; r < N; r++)
        req_data[r*36 +: 36] = {($urandom_range(0, 3) == 0), 3'($urandom), 32'($urandom)};
      flush = ($urandom_range(0, 19) == 0);
    end
    nc();
    req_valid = '0; flush = 1'b0;
    repeat (30) nc();
    check("scoreboard_empty", 64'(sbq.size()), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
